// File: rtl/io_write_buffer_pkg.sv
// io_write_buffer_pkg: shared width helpers and port-slice index helper for io_write_buffer
package io_write_buffer_pkg;

    // Pointer width for a power-of-two FIFO depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Count width: one extra bit so a full FIFO (count == depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Low bit index of slice idx inside a flat vector of width-bit words.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/io_port_fifo.sv
// io_port_fifo: single-port first-word-fall-through FIFO with registered almost-full flag
//   clock_i, reset_i        clock, async active-high reset
//   push_i, data_i          write strobe and word
//   ready_i                 consumer accepts head word
//   valid_o, data_o         head word available / head word (zero when not valid)
//   full_o                  registered almost-full flag
//   ovf_clear_i, overflow_o sticky drop flag, present only with IO_WRITE_BUFFER_OVERFLOW_EN
module io_port_fifo
    import io_write_buffer_pkg::*;
#(
    parameter int W          = 36,
    parameter int DEPTH      = 4,
    parameter int FULL_SLACK = 1
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
`ifdef IO_WRITE_BUFFER_OVERFLOW_EN
    input  logic         ovf_clear_i,
    output logic         overflow_o,
`endif
    output logic         full_o
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_AT = CW'(DEPTH - FULL_SLACK);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, pop, accept;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        pop    = (cnt_q != '0) & ready_i;
        accept = push_i & ((cnt_q < DEPTH_C) | pop);
        cnt_d  = cnt_q + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            wr_q   <= wr_q + PW'(accept);
            rd_q   <= rd_q + PW'(pop);
            cnt_q  <= cnt_d;
            full_q <= cnt_d >= FULL_AT;
        end
    end

    // Storage is deliberately not reset; valid gating hides stale entries.
    always_ff @(posedge clock_i) begin
        if (accept) mem_q[wr_q] <= data_i;
    end

`ifdef IO_WRITE_BUFFER_OVERFLOW_EN
    logic ovf_q;
    // A drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) ovf_q <= 1'b0;
        else         ovf_q <= (push_i & ~accept) | (ovf_q & ~ovf_clear_i);
    end
    assign overflow_o = ovf_q;
`endif

    assign valid_o = cnt_q != '0;
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign full_o  = full_q;

endmodule

// File: rtl/io_write_buffer.sv
// io_write_buffer: per-port write FIFOs between Memory I/O write ports and external devices
//   clock, reset                 clock, async active-high reset
//   io_wren, io_write_data       per-port write strobes and words from Memory
//   port_full                    registered per-port almost-full flag to issue logic
//   port_valid, port_ready       per-port valid/ready handshake to devices
//   port_data                    per-port head word, zero when not valid
//   overflow_clear, port_overflow  sticky drop flags, present only with IO_WRITE_BUFFER_OVERFLOW_EN
module io_write_buffer
    import io_write_buffer_pkg::*;
#(
    parameter int WORD_WIDTH = 36,
    parameter int PORT_COUNT = 4,
    parameter int DEPTH      = 4,
    parameter int FULL_SLACK = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [PORT_COUNT-1:0]            io_wren,
    input  logic [WORD_WIDTH*PORT_COUNT-1:0] io_write_data,
    output logic [PORT_COUNT-1:0]            port_full,
    output logic [PORT_COUNT-1:0]            port_valid,
    input  logic [PORT_COUNT-1:0]            port_ready,
`ifdef IO_WRITE_BUFFER_OVERFLOW_EN
    input  logic [PORT_COUNT-1:0]            overflow_clear,
    output logic [PORT_COUNT-1:0]            port_overflow,
`endif
    output logic [WORD_WIDTH*PORT_COUNT-1:0] port_data
);
    for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
        io_port_fifo #(
            .W         (WORD_WIDTH),
            .DEPTH     (DEPTH),
            .FULL_SLACK(FULL_SLACK)
        ) u_fifo (
            .clock_i    (clock),
            .reset_i    (reset),
            .push_i     (io_wren[g]),
            .data_i     (io_write_data[slice_lo(g, WORD_WIDTH) +: WORD_WIDTH]),
            .ready_i    (port_ready[g]),
            .valid_o    (port_valid[g]),
            .data_o     (port_data[slice_lo(g, WORD_WIDTH) +: WORD_WIDTH]),
`ifdef IO_WRITE_BUFFER_OVERFLOW_EN
            .ovf_clear_i(overflow_clear[g]),
            .overflow_o (port_overflow[g]),
`endif
            .full_o     (port_full[g])
        );
    end

endmodule

// File: tb/tb_io_write_buffer.sv
// tb_io_write_buffer: randomized and directed bench against a queue-based reference model
module tb_io_write_buffer;
    localparam int W  = 36;
    localparam int PC = 4;
    localparam int D  = 4;
    localparam int FS = 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [PC-1:0]     io_wren;
    logic [PC*W-1:0]   io_write_data;
    logic [PC-1:0]     port_full, port_valid, port_ready;
    logic [PC*W-1:0]   port_data;
`ifdef IO_WRITE_BUFFER_OVERFLOW_EN
    logic [PC-1:0]     overflow_clear, port_overflow;
    logic [PC-1:0]     movf;
`endif

    logic [W-1:0] mq [PC][$];
    logic [PC-1:0] mfull;
    int n_checks = 0;
    int n_fail   = 0;

    io_write_buffer #(.WORD_WIDTH(W), .PORT_COUNT(PC), .DEPTH(D), .FULL_SLACK(FS)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_wren       (io_wren),
        .io_write_data (io_write_data),
        .port_full     (port_full),
        .port_valid    (port_valid),
        .port_ready    (port_ready),
`ifdef IO_WRITE_BUFFER_OVERFLOW_EN
        .overflow_clear(overflow_clear),
        .port_overflow (port_overflow),
`endif
        .port_data     (port_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < PC; i++) mq[i].delete();
        mfull = '0;
`ifdef IO_WRITE_BUFFER_OVERFLOW_EN
        movf = '0;
`endif
    endtask

    task automatic compare_all(input string tag);
        logic [PC-1:0] ev;
        logic [PC*W-1:0] ed;
        ed = '0;
        for (int i = 0; i < PC; i++) begin
            ev[i] = mq[i].size() != 0;
            if (ev[i]) ed[i*W +: W] = mq[i][0];
        end
        check({tag, "_valid"}, 160'(port_valid), 160'(ev));
        check({tag, "_data"},  160'(port_data),  160'(ed));
        check({tag, "_full"},  160'(port_full),  160'(mfull));
`ifdef IO_WRITE_BUFFER_OVERFLOW_EN
        check({tag, "_ovf"},   160'(port_overflow), 160'(movf));
`endif
    endtask

    // Drive one cycle of inputs, advance the model by the spec's rules, then check after the edge.
    task automatic apply(input string tag, input logic [PC-1:0] wr, input logic [PC*W-1:0] d,
                         input logic [PC-1:0] rd);
        bit pop, acc;
        io_wren = wr;
        io_write_data = d;
        port_ready = rd;
        for (int i = 0; i < PC; i++) begin
            pop = mq[i].size() != 0 && rd[i];
            acc = wr[i] && (mq[i].size() < D || pop);
            if (pop) void'(mq[i].pop_front());
            if (acc) mq[i].push_back(d[i*W +: W]);
            mfull[i] = mq[i].size() >= D - FS;
`ifdef IO_WRITE_BUFFER_OVERFLOW_EN
            if (wr[i] && !acc) movf[i] = 1'b1;
            else if (overflow_clear[i]) movf[i] = 1'b0;
`endif
        end
        @(negedge clock);
        compare_all(tag);
    endtask

    function automatic logic [PC*W-1:0] word_at(input int p, input logic [W-1:0] v);
        logic [PC*W-1:0] r;
        r = '0;
        r[p*W +: W] = v;
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        io_wren = '0;
        io_write_data = '0;
        port_ready = '0;
`ifdef IO_WRITE_BUFFER_OVERFLOW_EN
        overflow_clear = '0;
`endif
        model_clear();
        repeat (2) @(negedge clock);
        compare_all("reset");
        reset = 1'b0;

        // 1: single word on port 2
        apply("s1", 4'b0100, word_at(2, 36'h0_0000_00AB), '0);
        check("s1_valid_exact", 160'(port_valid), 160'(4'b0100));
        check("s1_slice2", 160'(port_data[2*W +: W]), 160'(36'h0AB));
        apply("s1_drain", '0, '0, 4'b0100);

        // 2: fill port 0, almost-full after 3rd, 4th accepted, 5th dropped, then drain
        for (int k = 1; k <= 5; k++) begin
            apply("s2_fill", 4'b0001, word_at(0, W'(k)), '0);
            if (k == 3) check("s2_full_at3", 160'(port_full[0]), 160'(1'b1));
        end
        for (int k = 0; k < 5; k++) apply("s2_drain", '0, '0, 4'b0001);

        // 3: port 1 full, simultaneous push and pop keeps it full
        for (int k = 11; k <= 14; k++) apply("s3_fill", 4'b0010, word_at(1, W'(k)), '0);
        apply("s3_pp", 4'b0010, word_at(1, 36'h5), 4'b0010);
        check("s3_still_full", 160'(port_full[1]), 160'(1'b1));
        for (int k = 0; k < 5; k++) apply("s3_drain", '0, '0, 4'b0010);

        // 4: ten words through port 3 with ready toggling, pointers wrap twice
        for (int k = 0; k < 20; k++)
            apply("s4", (k % 2 == 0) ? 4'b1000 : 4'b0000, word_at(3, W'(k / 2 + 1)),
                  (k % 2 == 1) ? 4'b1000 : 4'b0000);

        // 5: all ports at once, then pop only port 0
        apply("s5_push", 4'b1111, {36'h4, 36'h3, 36'h2, 36'h1}, '0);
        apply("s5_pop0", '0, '0, 4'b0001);
        check("s5_valid", 160'(port_valid), 160'(4'b1110));
        apply("s5_drain", '0, '0, 4'b1111);

        // 6: async reset between edges with port 0 holding three words
        for (int k = 1; k <= 3; k++) apply("s6_fill", 4'b0001, word_at(0, W'(k + 32)), '0);
        #2 reset = 1'b1;
        #1;
        check("s6_valid", 160'(port_valid), 160'(0));
        check("s6_full",  160'(port_full),  160'(0));
        check("s6_data",  160'(port_data),  160'(0));
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        compare_all("s6_after");

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [PC*W-1:0] d;
            for (int i = 0; i < PC; i++) d[i*W +: W] = {4'($urandom), $urandom};
`ifdef IO_WRITE_BUFFER_OVERFLOW_EN
            overflow_clear = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
`endif
            apply("rnd", 4'($urandom) & 4'($urandom | $urandom), d, 4'($urandom) & 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
